// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: accepts a configuration bitstream as parallel words over a
// valid/ready handshake, pulses a clear into the configuration chain, then
// serialises exactly CHAIN_LEN bits into the chain head, LSB of each word first.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// CLEAR | config_reset held high for CLR_CYCLES cycles
// LOAD  | word_ready high; waiting for the next bitstream word
// SHIFT | one chain shift per cycle from the shift register LSB
// DONE  | one-cycle done pulse, then back to IDLE
module cfg_chain_loader #(
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 40,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              config_out,
    output logic              config_clk_en,
    output logic              config_reset,
    output logic              busy,
    output logic              done
);

    localparam int CW   = $clog2(CHAIN_LEN + 1);
    localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CLRW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]     bits_left_q, bits_left_d;
    logic [CW-1:0]     word_bits_q, word_bits_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;

    // State, counters and shift register; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            clr_cnt_q   <= '0;
            bits_left_q <= '0;
            word_bits_q <= '0;
            sreg_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            bits_left_q <= bits_left_d;
            word_bits_q <= word_bits_d;
            sreg_q      <= sreg_d;
        end
    end

    // Next-state, counter updates and Moore outputs; abort overrides everything.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        bits_left_d   = bits_left_q;
        word_bits_d   = word_bits_q;
        sreg_d        = sreg_q;
        word_ready    = 1'b0;
        config_out    = 1'b0;
        config_clk_en = 1'b0;
        config_reset  = 1'b0;
        done          = 1'b0;
        busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = CLRW'(CLR_CYCLES - 1);
                end
            end
            S_CLEAR: begin
                config_reset = 1'b1;
                if (clr_cnt_q == '0) begin
                    state_d     = S_LOAD;
                    bits_left_d = CW'(CHAIN_LEN);
                end else begin
                    clr_cnt_d = clr_cnt_q - CLRW'(1);
                end
            end
            S_LOAD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    sreg_d      = word_data;
                    // The last word may be partial; only the remaining bits get shifted.
                    word_bits_d = (int'(bits_left_q) > WORD_W) ? CW'(WORD_W) : bits_left_q;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                config_clk_en = 1'b1;
                config_out    = sreg_q[0];
                sreg_d        = sreg_q >> 1;
                if (word_bits_q != '0) begin
                    word_bits_d = word_bits_q - CW'(1);
                end
                if (bits_left_q != '0) begin
                    bits_left_d = bits_left_q - CW'(1);
                end
                if (bits_left_q <= CW'(1)) begin
                    state_d = S_DONE;
                end else if (word_bits_q == CW'(1)) begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Testbench for cfg_chain_loader: drives loads through the handshake and compares
// the serial stream, enable pattern and pulse timing against an arithmetic model.
module tb_cfg_chain_loader;

    localparam int WORD_W     = 32;
    localparam int CHAIN_LEN  = 40;
    localparam int CLR_CYCLES = 2;
    localparam int NW         = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              clk;
    logic              reset;
    logic              start, abort, word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready, config_out, config_clk_en, config_reset, busy, done;

    logic              start1, abort1, word_valid1;
    logic [WORD_W-1:0] word_data1;
    logic              word_ready1, config_out1, config_clk_en1, config_reset1, busy1, done1;

    int checks;
    int errors;

    logic [WORD_W-1:0] wq [0:3];
    int                stall_q [0:3];
    bit                rand_idle;
    bit                rand_start;

    cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .CLR_CYCLES(CLR_CYCLES)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .config_out(config_out), .config_clk_en(config_clk_en), .config_reset(config_reset),
        .busy(busy), .done(done)
    );

    cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(1), .CLR_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .word_valid(word_valid1), .word_data(word_data1), .word_ready(word_ready1),
        .config_out(config_out1), .config_clk_en(config_clk_en1), .config_reset(config_reset1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete load on the main instance; abort_bit >= 0 aborts while that stream bit is out.
    task automatic run_load(input string name, input int abort_bit);
        int k, idx, stall_cnt, en_cnt, done_cnt, done_k, accepts, clr_cnt, clr_first;
        int run, out_zero_err, stall_ready_err, abort_k, exp_done, remain;
        bit in_stall, timed_out, last_en, runs_ok;
        logic [CHAIN_LEN-1:0] got_bits, exp_bits;
        int runs[$];
        int exp_runs[$];

        k = 0; idx = 0; stall_cnt = 0; en_cnt = 0; done_cnt = 0; done_k = -1; accepts = 0;
        clr_cnt = 0; clr_first = -1; run = 0; out_zero_err = 0; stall_ready_err = 0;
        abort_k = -1; in_stall = 0; last_en = 0; got_bits = '0;

        for (int b = 0; b < CHAIN_LEN; b++) exp_bits[b] = wq[b / WORD_W][b % WORD_W];
        remain = CHAIN_LEN;
        while (remain > 0) begin
            exp_runs.push_back((remain > WORD_W) ? WORD_W : remain);
            remain -= (remain > WORD_W) ? WORD_W : remain;
        end
        exp_done = CLR_CYCLES + NW + CHAIN_LEN + 1;
        for (int i = 0; i < NW; i++) exp_done += stall_q[i];

        @(negedge clk);
        start = 1'b1; abort = 1'b0; word_valid = 1'b0;
        timed_out = 1'b1;
        while (k < 600) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            abort = 1'b0;
            if (config_reset) begin
                clr_cnt++;
                if (clr_first < 0) clr_first = k;
            end
            last_en = config_clk_en;
            if (config_clk_en) begin
                if (en_cnt < CHAIN_LEN) got_bits[en_cnt] = config_out;
                en_cnt++;
                run++;
            end else begin
                if (run > 0) runs.push_back(run);
                run = 0;
                if (config_out !== 1'b0) out_zero_err++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (in_stall && !word_ready) stall_ready_err++;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            if (abort_bit >= 0 && abort_k < 0 && config_clk_en && (en_cnt - 1) == abort_bit) begin
                abort = 1'b1;
                abort_k = k;
            end
            if (rand_start && $urandom_range(0, 5) == 0) start = 1'b1;
            if (word_ready) begin
                if (idx < NW && stall_cnt < stall_q[idx]) begin
                    word_valid = 1'b0;
                    stall_cnt++;
                    in_stall = 1'b1;
                end else begin
                    word_valid = 1'b1;
                    word_data = (idx < NW) ? wq[idx] : WORD_W'($urandom);
                    accepts++;
                    idx++;
                    stall_cnt = 0;
                    in_stall = 1'b0;
                end
            end else begin
                word_valid = rand_idle ? 1'($urandom_range(0, 1)) : 1'b1;
                word_data = WORD_W'($urandom);
            end
        end
        start = 1'b0; abort = 1'b0; word_valid = 1'b0;
        if (run > 0) runs.push_back(run);

        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s timeout: busy still %b after %0d cycles, required 0", name, busy, k);
        end

        if (abort_bit < 0) begin
            checks++;
            if (clr_first !== 1 || clr_cnt !== CLR_CYCLES) begin
                errors++;
                $display("FAIL %s config_reset: first=%0d len=%0d, required first=1 len=%0d",
                         name, clr_first, clr_cnt, CLR_CYCLES);
            end
            checks++;
            if (en_cnt !== CHAIN_LEN || got_bits !== exp_bits) begin
                errors++;
                $display("FAIL %s bitstream: got %0d bits %h, required %0d bits %h",
                         name, en_cnt, got_bits, CHAIN_LEN, exp_bits);
            end
            runs_ok = (runs.size() == exp_runs.size());
            if (runs_ok) foreach (runs[i]) if (runs[i] != exp_runs[i]) runs_ok = 1'b0;
            checks++;
            if (!runs_ok) begin
                errors++;
                $display("FAIL %s clk_en_runs: got %p, required %p", name, runs, exp_runs);
            end
            checks++;
            if (done_cnt !== 1 || done_k !== exp_done) begin
                errors++;
                $display("FAIL %s done: pulses=%0d at cycle %0d, required 1 at cycle %0d",
                         name, done_cnt, done_k, exp_done);
            end
            checks++;
            if (k !== exp_done + 1) begin
                errors++;
                $display("FAIL %s busy_drop: idle at cycle %0d, required %0d", name, k, exp_done + 1);
            end
            checks++;
            if (accepts !== NW) begin
                errors++;
                $display("FAIL %s words_accepted: got %0d, required %0d", name, accepts, NW);
            end
            checks++;
            if (out_zero_err !== 0) begin
                errors++;
                $display("FAIL %s config_out_idle: %0d cycles nonzero with clk_en low, required 0",
                         name, out_zero_err);
            end
            checks++;
            if (stall_ready_err !== 0) begin
                errors++;
                $display("FAIL %s ready_in_stall: dropped %0d cycles, required 0", name, stall_ready_err);
            end
        end else begin
            checks++;
            if (k !== abort_k + 1 || last_en !== 1'b0) begin
                errors++;
                $display("FAIL %s abort_idle: idle at cycle %0d clk_en=%b, required cycle %0d clk_en=0",
                         name, k, last_en, abort_k + 1);
            end
            checks++;
            if (done_cnt !== 0) begin
                errors++;
                $display("FAIL %s abort_no_done: got %0d pulses, required 0", name, done_cnt);
            end
            runs_ok = (en_cnt == abort_bit + 1);
            for (int b = 0; b <= abort_bit && b < CHAIN_LEN; b++)
                if (got_bits[b] !== exp_bits[b]) runs_ok = 1'b0;
            checks++;
            if (!runs_ok) begin
                errors++;
                $display("FAIL %s abort_prefix: got %0d bits, required %0d matching bits",
                         name, en_cnt, abort_bit + 1);
            end
            repeat (4) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            checks++;
            if (done_cnt !== 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s abort_quiet: done pulses=%0d busy=%b, required 0 and 0",
                         name, done_cnt, busy);
            end
        end
    endtask

    task automatic set_nominal();
        wq[0] = 32'hA5A5_0F0F; wq[1] = 32'h0000_00C3; wq[2] = '0; wq[3] = '0;
        for (int i = 0; i < 4; i++) stall_q[i] = 0;
        rand_idle = 1'b0; rand_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({word_ready, config_out, config_clk_en, config_reset, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {word_ready, config_out, config_clk_en, config_reset, busy, done});
        end
        checks++;
        if ({word_ready1, config_out1, config_clk_en1, config_reset1, busy1, done1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs_1bit: got %b, required 000000",
                     {word_ready1, config_out1, config_clk_en1, config_reset1, busy1, done1});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        set_nominal();
        run_load("nominal", -1);
    endtask

    task automatic test_backpressure();
        set_nominal();
        stall_q[0] = 5; stall_q[1] = 5;
        run_load("backpressure", -1);
    endtask

    task automatic test_partial();
        set_nominal();
        wq[1] = 32'hFFFF_FF00;
        run_load("partial", -1);
    endtask

    task automatic test_abort();
        set_nominal();
        run_load("abort", 20);
        run_load("after_abort", -1);
    endtask

    task automatic test_async_reset();
        int n, guard;
        set_nominal();
        n = 0; guard = 0;
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_data = WORD_W'($urandom);
        while (n < 10 && guard < 200) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (config_clk_en) n++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL async_reach_shift: saw %0d shifts, required 10", n);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({word_ready, config_out, config_clk_en, config_reset, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b, required 000000",
                     {word_ready, config_out, config_clk_en, config_reset, busy, done});
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || config_reset !== 1'b0) begin
            errors++;
            $display("FAIL async_start_in_reset: busy=%b config_reset=%b, required 0 0", busy, config_reset);
        end
        reset = 1'b1;
        word_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || config_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL async_release_idle: busy=%b clk_en=%b, required 0 0", busy, config_clk_en);
        end
        run_load("after_reset", -1);
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || config_reset !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b config_reset=%b, required 0 0", busy, config_reset);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle_hold: busy=%b, required 0", busy);
        end
    endtask

    // CHAIN_LEN=1, CLR_CYCLES=1: expected done at cycle 1 + 1 + 1 + 1.
    task automatic test_single_bit(input logic b0);
        int k, en_cnt, accepts, done_k;
        logic got;
        logic [WORD_W-1:0] w;
        bit timed_out;
        w = WORD_W'($urandom);
        w[0] = b0;
        k = 0; en_cnt = 0; accepts = 0; done_k = -1; got = 1'bx; timed_out = 1'b1;
        @(negedge clk);
        start1 = 1'b1; abort1 = 1'b0; word_valid1 = 1'b1; word_data1 = w;
        while (k < 50) begin
            @(negedge clk);
            k++;
            start1 = 1'b0;
            if (config_clk_en1) begin
                en_cnt++;
                got = config_out1;
            end
            if (done1 && done_k < 0) done_k = k;
            if (!busy1) begin
                timed_out = 1'b0;
                break;
            end
            if (word_ready1) accepts++;
            word_data1 = w;
        end
        word_valid1 = 1'b0;
        checks++;
        if (timed_out || en_cnt !== 1 || got !== b0 || accepts !== 1 || done_k !== 4) begin
            errors++;
            $display("FAIL single_bit: shifts=%0d bit=%b words=%0d done_at=%0d, required 1 %b 1 4",
                     en_cnt, got, accepts, done_k, b0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 4; i++) begin
                wq[i] = WORD_W'($urandom);
                stall_q[i] = $urandom_range(0, 3);
            end
            rand_idle = 1'b1;
            rand_start = 1'b1;
            run_load($sformatf("random%0d", it), -1);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
        start1 = 1'b0; abort1 = 1'b0; word_valid1 = 1'b0; word_data1 = '0;
        rand_idle = 1'b0; rand_start = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_partial();
        test_abort();
        test_async_reset();
        test_start_abort_idle();
        test_single_bit(1'b1);
        test_single_bit(1'b0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
